mealy_seq_detect: RTL and testbench
===================================

MEALY_SEQ_DETECT -- requirements
Module: mealy_seq_detect

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits; the legal range is 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 din  in  1  SHALL be the serial data bit.
REQ-006 din_valid  in  1  SHALL qualify din; din is ignored when din_valid is low.
REQ-007 load  in  1  SHALL be a one-cycle strobe that loads pat, pat_len and overlap.
REQ-008 pat  in  MAX_LEN  SHALL carry the pattern, with pat[pat_len-1] first received and pat[0] last received.
REQ-009 pat_len  in  $clog2(MAX_LEN+1)  SHALL carry the pattern length.
REQ-010 overlap  in  1  SHALL select the match mode: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-011 y  out  1  SHALL be the Mealy match output: combinational from state, din and din_valid.
REQ-012 match_cnt  out  CNT_W  SHALL hold the saturating count of matches.
REQ-013 cfg_err  out  1  SHALL pulse registered for one cycle on a rejected load.
REQ-014 armed  out  1  SHALL be high while a valid pattern is loaded.

Function
REQ-015 The FSM SHALL have two states: IDLE (no pattern) and RUN; IDLE->RUN on a valid load; RUN->RUN on a valid load (reconfigure); no other transitions except reset.
REQ-016 A load SHALL be valid iff 2 <= pat_len <= MAX_LEN; an invalid load SHALL leave the state and configuration unchanged and assert cfg_err in the following cycle.
REQ-017 A valid load SHALL latch the configuration, clear the history register and hist_cnt, and clear match_cnt.
REQ-018 din_valid in the same cycle as load SHALL be ignored, and y SHALL be 0 in that cycle.
REQ-019 In RUN, each din_valid beat SHALL shift din into a MAX_LEN-bit history, LSB newest, and increment hist_cnt, saturating at MAX_LEN.
REQ-020 y SHALL equal din_valid AND state==RUN AND hist_cnt >= pat_len-1 AND {history[pat_len-2:0], din} == pat[pat_len-1:0], with zero latency in the same cycle.
REQ-021 In IDLE, y SHALL be 0, the history SHALL be held, and beats SHALL be ignored.
REQ-022 On a match with overlap=1, the beat SHALL be shifted in normally, so a suffix can begin the next match.
REQ-023 On a match with overlap=0, hist_cnt SHALL be cleared, so the next match requires pat_len fresh beats.
REQ-024 match_cnt SHALL increment by 1 on each cycle y=1 and saturate at 2^CNT_W-1 without wrap.
REQ-025 Unused high bits of pat (index >= pat_len) SHALL be don't-care.

Reset
REQ-026 reset SHALL force state=IDLE, history=0, hist_cnt=0, match_cnt=0, cfg_err=0, armed=0 and stored configuration=0.
REQ-027 reset SHALL take priority over load and din_valid in the same cycle.
REQ-028 y SHALL be 0 during any cycle in which reset is high.
REQ-029 After reset, a new load SHALL be required before any match can occur.

Structure
REQ-030 A shared package mealy_seq_pkg SHALL hold the state enum (IDLE, RUN) and the constants MAX_LEN_LIMIT=16 and MIN_LEN=2.
REQ-031 The saturating counter SHALL be a sub-module sat_counter, parametrised by width, with inputs clr and inc.
REQ-032 The compare SHALL be a masked equality over MAX_LEN bits, with the mask derived from pat_len.

Verification
REQ-033 Overlapping match: load pat=101, len=3, overlap=1; beats 1,0,1,0,1 -> y=1 on beats 3 and 5; match_cnt=2.
REQ-034 Non-overlapping match: same as REQ-033 with overlap=0 -> y=1 on beat 3 only; match_cnt=1.
REQ-035 Overlap contrast: load pat=1011, len=4; beats 1,0,1,1,0,1,1 -> overlap=1 gives y on beats 4 and 7 (cnt 2); overlap=0 gives y on beat 4 only (cnt 1).
REQ-036 Invalid loads: load pat_len=1, then pat_len=MAX_LEN+1 -> cfg_err pulses once per load, armed stays 0, and y stays 0 for the stream 1,1,1.
REQ-037 Saturation: CNT_W=2, pat=11, len=2, overlap=1; beats 1x6 -> y on beats 2..6; match_cnt=1,2,3,3,3.
REQ-038 Mid-operation events: pat=101, len=3, overlap=1; after beats 1,0, assert reset, reload the same pattern, then beat 1 -> no y; then beats 0,1 -> y on the last beat; also a load during valid data -> that beat is ignored.

Source files
------------

// File: rtl/mealy_seq_pkg.sv
// Shared types and constants for the Mealy serial pattern detector.
// Holds the FSM state encoding and the pattern-length legality rule.
package mealy_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MAX_LEN_LIMIT = 16;
    localparam int unsigned MIN_LEN       = 2;

    // A pattern length is usable only if it fits the history of this instance.
    function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
        return (len >= MIN_LEN) && (len <= max_len) && (max_len <= MAX_LEN_LIMIT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear takes priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mealy_seq_detect.sv
// Loadable serial pattern detector with a zero-latency Mealy match output,
// selectable overlapping/non-overlapping matching and a saturating match count.
module mealy_seq_detect
    import mealy_seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         load,
    input  logic [MAX_LEN-1:0]           pat,
    input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
    input  logic                         overlap,
    output logic                         y,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err,
    output logic                         armed
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   hcnt_q, hcnt_d;
    logic               ovl_q, ovl_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic               load_ok;
    logic               beat;
    logic               enough;
    logic               pat_eq;
    logic               unused_hist_msb;

    assign load_ok = load && len_valid(32'(pat_len), MAX_LEN);

    // Oldest history bit only matters for a full-width shift; it never reaches the compare.
    assign unused_hist_msb = hist_q[MAX_LEN-1];
    assign window          = {hist_q[MAX_LEN-2:0], din};

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    // len_q >= MIN_LEN whenever state is RUN, so the subtraction cannot underflow there.
    assign enough = (hcnt_q >= (len_q - LEN_W'(1)));
    assign pat_eq = (((window ^ pat_q) & mask) == '0);
    assign beat   = din_valid && !load && !reset && (state_q == RUN);
    assign y      = beat && enough && pat_eq;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        hcnt_d    = hcnt_q;
        ovl_d     = ovl_q;
        cfg_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                state_d = RUN;
                pat_d   = pat;
                len_d   = pat_len;
                ovl_d   = overlap;
                hist_d  = '0;
                hcnt_d  = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (beat) begin
            hist_d = window;
            if (y && !ovl_q) begin
                hcnt_d = '0;
            end else if (hcnt_q != LEN_W'(MAX_LEN)) begin
                hcnt_d = hcnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            hcnt_q    <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            hcnt_q    <= hcnt_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load_ok),
        .inc   (y),
        .cnt   (match_cnt)
    );

    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == RUN);

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Bench for mealy_seq_detect: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mealy_seq_detect;

    logic       clk = 1'b0;
    logic       reset, din, din_valid, load, overlap;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       y, y2, cfg_err, cfg_err2, armed, armed2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;
    logic last_y;

    // Reference model state
    bit       m_armed;
    int       m_len;
    logic [7:0] m_pat;
    bit       m_ovl;
    bit       m_cfg_err;
    int       m_cnt, m_cnt2;
    bit       q[$];

    always #5 clk = ~clk;

    mealy_seq_detect #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap), .y(y),
        .match_cnt(match_cnt), .cfg_err(cfg_err), .armed(armed)
    );

    mealy_seq_detect #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap), .y(y2),
        .match_cnt(match_cnt2), .cfg_err(cfg_err2), .armed(armed2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Match iff the last m_len received bits (current din newest) spell the pattern.
    function automatic bit exp_y();
        int n;
        bit b;
        if (reset || load || !din_valid || !m_armed) return 1'b0;
        n = q.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == m_len - 1) ? din : q[n - (m_len - 1) + k];
            if (b != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit ey;
        ey = exp_y();
        if (reset) begin
            m_armed = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_cfg_err = 0;
            m_cnt = 0; m_cnt2 = 0; q.delete();
        end else begin
            m_cfg_err = 0;
            if (load) begin
                if (pat_len >= 2 && pat_len <= 8) begin
                    m_armed = 1; m_len = int'(pat_len); m_pat = pat; m_ovl = overlap;
                    m_cnt = 0; m_cnt2 = 0; q.delete();
                end else begin
                    m_cfg_err = 1;
                end
            end else if (m_armed && din_valid) begin
                if (ey) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
                if (ey && !m_ovl) q.delete();
                else begin
                    q.push_back(din);
                    if (q.size() > 16) void'(q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("y", y, exp_y());
            chk("y_cnt2", y2, exp_y());
            chk("match_cnt", match_cnt, m_cnt);
            chk("match_cnt_cnt2", match_cnt2, m_cnt2);
            chk("armed", armed, m_armed);
            chk("cfg_err", cfg_err, m_cfg_err);
        end
    end

    task automatic tick();
        #2 last_y = y;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
        load = 1; pat = p; pat_len = l; overlap = o; din_valid = 0;
        tick();
        load = 0;
    endtask

    task automatic beat(input logic b);
        load = 0; din = b; din_valid = 1;
        tick();
        din_valid = 0;
    endtask

    task automatic run_beats(input logic [15:0] bits, input int n, output logic [15:0] ys);
        ys = '0;
        for (int i = 0; i < n; i++) begin
            beat(bits[n-1-i]);
            ys[n-1-i] = last_y;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        logic [15:0] ys;
        int exp37[6];
        logic [5:0] y37;
        exp37 = '{0, 1, 2, 3, 3, 3};

        reset = 1; din = 0; din_valid = 0; load = 0; overlap = 0; pat = '0; pat_len = '0;
        tick();
        started = 1'b1;
        tick();
        reset = 0;
        chk("rst_armed", armed, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // Overlapping 101
        do_load(8'b101, 3, 1);
        chk("load_armed", armed, 1);
        run_beats(16'b10101, 5, ys);
        chk("ovl101_y", ys, 16'b00101);
        chk("ovl101_cnt", match_cnt, 2);

        // Non-overlapping 101
        do_load(8'b101, 3, 0);
        chk("reload_clr_cnt", match_cnt, 0);
        run_beats(16'b10101, 5, ys);
        chk("novl101_y", ys, 16'b00100);
        chk("novl101_cnt", match_cnt, 1);

        // 1011 overlap contrast
        do_load(8'b1011, 4, 1);
        run_beats(16'b1011011, 7, ys);
        chk("ovl1011_y", ys, 16'b0001001);
        chk("ovl1011_cnt", match_cnt, 2);
        do_load(8'b1011, 4, 0);
        run_beats(16'b1011011, 7, ys);
        chk("novl1011_y", ys, 16'b0001000);
        chk("novl1011_cnt", match_cnt, 1);

        // High pattern bits beyond pat_len are ignored
        do_load(8'b11110101, 3, 1);
        run_beats(16'b101, 3, ys);
        chk("dontcare_y", ys, 16'b001);

        // Full-length pattern, repeated
        do_load(8'b10010110, 8, 1);
        run_beats(16'b1001011010010110, 16, ys);
        chk("len8_y", ys, 16'b0000000100000001);
        chk("len8_cnt", match_cnt, 2);

        // Invalid loads from IDLE
        do_reset();
        do_load(8'b101, 1, 1);
        chk("bad1_cfg_err", cfg_err, 1);
        chk("bad1_armed", armed, 0);
        tick();
        chk("bad1_cfg_err_drop", cfg_err, 0);
        do_load(8'b101, 9, 1);
        chk("bad9_cfg_err", cfg_err, 1);
        chk("bad9_armed", armed, 0);
        tick();
        chk("bad9_cfg_err_drop", cfg_err, 0);
        run_beats(16'b111, 3, ys);
        chk("idle_y", ys, 16'b000);

        // Saturation on the 2-bit counter instance
        do_load(8'b11, 2, 1);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1);
            y37[5-i] = last_y;
            chk("sat_cnt2", match_cnt2, exp37[i]);
        end
        chk("sat_y", y37, 6'b011111);
        chk("sat_cnt8", match_cnt, 5);

        // Reset mid-stream, then reload
        do_load(8'b101, 3, 1);
        run_beats(16'b10, 2, ys);
        do_reset();
        chk("midrst_armed", armed, 0);
        do_load(8'b101, 3, 1);
        run_beats(16'b1, 1, ys);
        chk("midrst_first_y", ys, 16'b0);
        run_beats(16'b01, 2, ys);
        chk("midrst_y", ys, 16'b01);
        chk("midrst_cnt", match_cnt, 1);

        // Load coinciding with a valid beat: the beat is dropped
        load = 1; pat = 8'b101; pat_len = 3; overlap = 1; din = 1; din_valid = 1;
        tick();
        chk("load_beat_y", last_y, 0);
        load = 0; din_valid = 0;
        run_beats(16'b01, 2, ys);
        chk("load_beat_dropped", ys, 16'b00);
        run_beats(16'b01, 2, ys);
        chk("after_drop_y", ys, 16'b01);

        // Invalid load while running keeps the old configuration
        do_load(8'b111, 0, 0);
        chk("run_bad_cfg_err", cfg_err, 1);
        chk("run_bad_armed", armed, 1);
        run_beats(16'b01, 2, ys);
        chk("run_bad_keep_y", ys, 16'b01);
        chk("run_bad_cnt", match_cnt, 2);

        // Reset wins over a simultaneous load
        reset = 1; load = 1; pat = 8'b101; pat_len = 3; overlap = 1;
        tick();
        reset = 0; load = 0;
        chk("rst_load_armed", armed, 0);
        run_beats(16'b101, 3, ys);
        chk("rst_load_y", ys, 16'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
